// File: rtl/ecpu_add16_seq_pkg.sv
// Shared constants and FSM encoding for the sequential 16-bit adder stage.
// ECPU_ALU_SUB_EN (optional define) enables the subtract path in the top and interface.
package ecpu_add16_seq_pkg;

    localparam int ADD_BYTE_W = 8;

    typedef enum logic [1:0] {
        ECPU_ADDSEQ_IDLE = 2'd0,
        ECPU_ADDSEQ_LO   = 2'd1,
        ECPU_ADDSEQ_HI   = 2'd2,
        ECPU_ADDSEQ_DONE = 2'd3
    } addseq_state_t;

endpackage

// File: rtl/ecpu_add16_seq_if.sv
// Operand and result handshakes of the sequential adder stage.
// ECPU_ALU_SUB_EN adds the in_sub select to the operand side.
interface ecpu_add16_seq_if;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
`ifdef ECPU_ALU_SUB_EN
    logic        in_sub;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_carry;
    logic        out_zero;

`ifdef ECPU_ALU_SUB_EN
    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_zero
    );
    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_zero
    );
`else
    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_zero
    );
    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_zero
    );
`endif

endinterface

// File: rtl/ecpu_add16_seq_add8_slice.sv
// Combinational byte adder with carry-in; the one slice the 16-bit stage time-shares.
module ecpu_add8_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/ecpu_add16_seq.sv
// 16-bit add (optionally subtract under ECPU_ALU_SUB_EN) computed in two byte passes
// through a single 8-bit slice, with valid/ready handshakes on both sides.
module ecpu_add16_seq
    import ecpu_add16_seq_pkg::*;
#(
    parameter int WIDTH_BYTE = ADD_BYTE_W
) (
    input  logic clk,
    input  logic rst_n,
    ecpu_add16_seq_if.slave bus
);

    localparam int W2 = 2 * WIDTH_BYTE;

    addseq_state_t         state;
    logic [W2-1:0]         a_q;
    logic [W2-1:0]         b_q;
    logic [WIDTH_BYTE-1:0] sum_lo;
    logic                  c8;
`ifdef ECPU_ALU_SUB_EN
    logic                  sub_q;
`endif

    logic                  accept;
    logic                  hi_pass;
    logic [WIDTH_BYTE-1:0] a_byte;
    logic [WIDTH_BYTE-1:0] b_sel;
    logic [WIDTH_BYTE-1:0] b_byte;
    logic                  cin_lo;
    logic                  cin;
    logic [WIDTH_BYTE-1:0] s_byte;
    logic                  c_byte;

    assign bus.in_ready = (state == ECPU_ADDSEQ_IDLE) ||
                          (state == ECPU_ADDSEQ_DONE && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // Operand muxes select which byte the shared slice sees this cycle.
    assign hi_pass = (state == ECPU_ADDSEQ_HI);
    assign a_byte  = hi_pass ? a_q[W2-1:WIDTH_BYTE] : a_q[WIDTH_BYTE-1:0];
    assign b_sel   = hi_pass ? b_q[W2-1:WIDTH_BYTE] : b_q[WIDTH_BYTE-1:0];
`ifdef ECPU_ALU_SUB_EN
    assign b_byte  = sub_q ? ~b_sel : b_sel;
    assign cin_lo  = sub_q;
`else
    assign b_byte  = b_sel;
    assign cin_lo  = 1'b0;
`endif
    assign cin     = hi_pass ? c8 : cin_lo;

    ecpu_add8_slice #(.W(WIDTH_BYTE)) u_slice (
        .a    (a_byte),
        .b    (b_byte),
        .cin  (cin),
        .sum  (s_byte),
        .cout (c_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ECPU_ADDSEQ_IDLE;
            a_q           <= '0;
            b_q           <= '0;
            sum_lo        <= '0;
            c8            <= 1'b0;
`ifdef ECPU_ALU_SUB_EN
            sub_q         <= 1'b0;
`endif
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_carry <= 1'b0;
            bus.out_zero  <= 1'b0;
        end else begin
            if (accept) begin
                a_q   <= bus.in_a;
                b_q   <= bus.in_b;
`ifdef ECPU_ALU_SUB_EN
                sub_q <= bus.in_sub;
`endif
            end
            case (state)
                ECPU_ADDSEQ_IDLE: begin
                    if (accept) state <= ECPU_ADDSEQ_LO;
                end
                ECPU_ADDSEQ_LO: begin
                    sum_lo <= s_byte;
                    c8     <= c_byte;
                    state  <= ECPU_ADDSEQ_HI;
                end
                ECPU_ADDSEQ_HI: begin
                    bus.out_sum   <= {s_byte, sum_lo};
                    bus.out_carry <= c_byte;
                    bus.out_zero  <= ({s_byte, sum_lo} == '0);
                    bus.out_valid <= 1'b1;
                    state         <= ECPU_ADDSEQ_DONE;
                end
                ECPU_ADDSEQ_DONE: begin
                    // A new accept here chains straight into LO without a bubble.
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= accept ? ECPU_ADDSEQ_LO : ECPU_ADDSEQ_IDLE;
                    end
                end
                default: state <= ECPU_ADDSEQ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ecpu_add16_seq.sv
// Directed bench for ecpu_add16_seq: vector table plus backpressure and mid-op reset sequences.
module tb_ecpu_add16_seq;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    ecpu_add16_seq_if bus ();

    ecpu_add16_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] sum;
        logic        carry;
        logic        zero;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_in(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic v);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = v;
`ifdef ECPU_ALU_SUB_EN
        bus.in_sub   = sub;
`else
        if (sub) $display("note: subtract vector skipped in add-only build");
`endif
    endtask

    // Waits (bounded) for out_valid after an accept edge; returns edges counted.
    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!bus.out_valid && cnt < 10) begin
            @(posedge clk); #1;
            cnt++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int cnt;
        @(negedge clk);
        drive_in(v.a, v.b, v.sub, 1'b1);
        bus.out_ready = 1'b1;
        chk({v.name, ".in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk({v.name, ".early_valid"}, {31'd0, bus.out_valid}, 32'd0);
        wait_valid(cnt);
        chk({v.name, ".latency"}, cnt, 32'd2);
        chk({v.name, ".sum"}, {16'd0, bus.out_sum}, {16'd0, v.sum});
        chk({v.name, ".carry"}, {31'd0, bus.out_carry}, {31'd0, v.carry});
        chk({v.name, ".zero"}, {31'd0, bus.out_zero}, {31'd0, v.zero});
        @(posedge clk); #1;
        chk({v.name, ".consumed"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        int cnt;
        n_tests = 0;
        n_fail  = 0;
        vecs.push_back('{"add150",   16'd150,   16'd150,   1'b0, 16'h012C, 1'b0, 1'b0});
        vecs.push_back('{"add65532", 16'd65532, 16'd65532, 1'b0, 16'hFFF8, 1'b1, 1'b0});
        vecs.push_back('{"lo_carry", 16'h00FF,  16'h0001,  1'b0, 16'h0100, 1'b0, 1'b0});
        vecs.push_back('{"wrap",     16'hFFFF,  16'h0001,  1'b0, 16'h0000, 1'b1, 1'b1});
        vecs.push_back('{"mixed",    16'h1234,  16'h4321,  1'b0, 16'h5555, 1'b0, 1'b0});
        vecs.push_back('{"hi_only",  16'h8000,  16'h8000,  1'b0, 16'h0000, 1'b1, 1'b1});
        vecs.push_back('{"zeros",    16'h0000,  16'h0000,  1'b0, 16'h0000, 1'b0, 1'b1});
`ifdef ECPU_ALU_SUB_EN
        vecs.push_back('{"sub5_7",   16'd5,     16'd7,     1'b1, 16'hFFFE, 1'b0, 1'b0});
        vecs.push_back('{"sub7_7",   16'd7,     16'd7,     1'b1, 16'h0000, 1'b1, 1'b1});
        vecs.push_back('{"sub_big",  16'h1200,  16'h0034,  1'b1, 16'h11CC, 1'b1, 1'b0});
`endif

        rst_n         = 1'b0;
        bus.out_ready = 1'b0;
        drive_in(16'hAAAA, 16'h5555, 1'b0, 1'b0);
        #23;
        chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst.out_sum",   {16'd0, bus.out_sum},   32'd0);
        chk("rst.out_carry", {31'd0, bus.out_carry}, 32'd0);
        chk("rst.out_zero",  {31'd0, bus.out_zero},  32'd0);
        chk("rst.in_ready",  {31'd0, bus.in_ready},  32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: hold result 5 cycles while a new operand pair waits.
        @(negedge clk);
        drive_in(16'h1111, 16'h2222, 1'b0, 1'b1);
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        drive_in(16'h0F0F, 16'h0101, 1'b0, 1'b1);
        wait_valid(cnt);
        chk("bp.latency", cnt, 32'd2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp.in_ready",  {31'd0, bus.in_ready},  32'd0);
            chk("bp.out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp.out_sum",   {16'd0, bus.out_sum},   32'h3333);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp.release_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        drive_in(16'hDEAD, 16'hBEEF, 1'b0, 1'b0);
        chk("bp.drop_valid", {31'd0, bus.out_valid}, 32'd0);
        wait_valid(cnt);
        chk("bp.next_latency", cnt, 32'd2);
        chk("bp.next_sum", {16'd0, bus.out_sum}, 32'h1010);
        @(posedge clk); #1;

        // Reset asserted while the high pass is in flight.
        @(negedge clk);
        drive_in(16'h00FF, 16'h0001, 1'b0, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mrst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mrst.out_sum",   {16'd0, bus.out_sum},   32'd0);
        chk("mrst.out_carry", {31'd0, bus.out_carry}, 32'd0);
        chk("mrst.in_ready",  {31'd0, bus.in_ready},  32'd1);
        @(posedge clk); #1;
        chk("mrst.held_valid", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec('{"post_rst", 16'h0F00, 16'h0100, 1'b0, 16'h1000, 1'b0, 1'b0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
